// File: rtl/data_memory_lsu_if.sv
// Load/store bus between the core datapath and the data memory LSU.
// The master side (core) drives the access request and samples the load
// result, the fault indication and the sticky error flag.
interface data_memory_lsu_if;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        misaligned;
  logic        err_sticky;

  modport master (
    output MemRead, MemWrite, funct3, Address, Write_data,
    input  Read_data, misaligned, err_sticky
  );

  modport slave (
    input  MemRead, MemWrite, funct3, Address, Write_data,
    output Read_data, misaligned, err_sticky
  );
endinterface

// File: rtl/data_memory_lsu.sv
// Data memory with load/store alignment for the single-cycle RISC-V core.
// Loads are combinational (zero latency); stores commit on the rising edge
// with per-byte lane enables. Misaligned or illegal-funct3 accesses are
// flagged combinationally, never touch memory, and set a sticky error flag.
// Optional macro DMEM_PERF_CNT_EN adds load_count/store_count outputs that
// count non-faulting loads and stores.
module data_memory_lsu #(
  parameter int DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  data_memory_lsu_if.slave   bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]        load_count,
  output logic [31:0]        store_count
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);

  // Storage and sticky error state
  logic [31:0] mem_q [DEPTH];
  logic        err_sticky_q;

  // Access decode
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_off;
  logic              illegal_f3;
  logic              align_bad;
  logic              access_en;
  logic              fault;
  logic              load_ok;
  logic              store_ok;

  // Store lane steering
  logic [3:0]        store_be;
  logic [31:0]       store_wdata;

  // Load lane selection
  logic [31:0]       rd_word;
  logic [31:0]       rd_shifted;
  logic [31:0]       load_value;

  // Upper address bits are dropped so accesses wrap modulo DEPTH words.
  assign word_idx  = bus.Address[ADDR_W+1:2];
  assign byte_off  = bus.Address[1:0];
  assign access_en = bus.MemRead | bus.MemWrite;

  // Classify funct3 legality and alignment for the current access
  always_comb begin
    illegal_f3 = 1'b0;
    align_bad  = 1'b0;
    case (bus.funct3)
      3'b000:  align_bad = 1'b0;
      3'b001:  align_bad = byte_off[0];
      3'b010:  align_bad = |byte_off;
      // Unsigned loads have no store counterpart.
      3'b100:  begin
        align_bad  = 1'b0;
        illegal_f3 = bus.MemWrite;
      end
      3'b101:  begin
        align_bad  = byte_off[0];
        illegal_f3 = bus.MemWrite;
      end
      default: illegal_f3 = 1'b1;
    endcase
  end

  assign fault    = access_en & (illegal_f3 | align_bad);
  assign load_ok  = bus.MemRead  & ~fault;
  assign store_ok = bus.MemWrite & ~fault;

  // Replicate store data across lanes and enable only the addressed ones
  always_comb begin
    store_be    = 4'b0000;
    store_wdata = 32'h0;
    case (bus.funct3[1:0])
      2'b00: begin
        store_wdata = {4{bus.Write_data[7:0]}};
        store_be    = 4'b0001 << byte_off;
      end
      2'b01: begin
        store_wdata = {2{bus.Write_data[15:0]}};
        store_be    = byte_off[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        store_wdata = bus.Write_data;
        store_be    = 4'b1111;
      end
      default: begin
        store_wdata = 32'h0;
        store_be    = 4'b0000;
      end
    endcase
  end

  // Memory array: cleared on reset, byte-lane writes on good stores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (store_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (store_be[b]) begin
          mem_q[word_idx][8*b +: 8] <= store_wdata[8*b +: 8];
        end
      end
    end
  end

  // Extract and extend the addressed lane from pre-edge contents
  always_comb begin
    rd_word    = mem_q[word_idx];
    rd_shifted = rd_word >> {byte_off, 3'b000};
    load_value = 32'h0;
    case (bus.funct3)
      3'b000:  load_value = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  load_value = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b010:  load_value = rd_word;
      3'b100:  load_value = {24'h0, rd_shifted[7:0]};
      3'b101:  load_value = {16'h0, rd_shifted[15:0]};
      default: load_value = 32'h0;
    endcase
    if (!load_ok) begin
      load_value = 32'h0;
    end
  end

  // Error flag latches on any faulting access; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else if (fault) begin
      err_sticky_q <= 1'b1;
    end
  end

  assign bus.Read_data  = load_value;
  assign bus.misaligned = fault;
  assign bus.err_sticky = err_sticky_q;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] load_count_q;
  logic [31:0] store_count_q;

  // Count non-faulting loads and stores; both wrap naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count_q  <= 32'h0;
      store_count_q <= 32'h0;
    end else begin
      if (load_ok) begin
        load_count_q <= load_count_q + 32'd1;
      end
      if (store_ok) begin
        store_count_q <= store_count_q + 32'd1;
      end
    end
  end

  assign load_count  = load_count_q;
  assign store_count = store_count_q;
`endif

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed, table-driven bench for data_memory_lsu. Each vector is driven on
// the falling edge, its combinational outputs are compared 1 ns later, and
// any store commits on the following rising edge.
module tb_data_memory_lsu;

  logic clk;
  logic rst_n;

  data_memory_lsu_if bus ();

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] load_count;
  logic [31:0] store_count;
`endif

  data_memory_lsu #(.DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef DMEM_PERF_CNT_EN
    ,
    .load_count  (load_count),
    .store_count (store_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(string name, logic rd, logic wr, logic [2:0] f3,
                              logic [31:0] addr, logic [31:0] wd,
                              logic [31:0] exp_rd, logic exp_mis, logic exp_err);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_mis = exp_mis; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, got);
    end
  endtask

  task automatic drive(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd);
    bus.MemRead    = rd;
    bus.MemWrite   = wr;
    bus.funct3     = f3;
    bus.Address    = addr;
    bus.Write_data = wd;
  endtask

  task automatic run_vec(vec_t v);
    @(negedge clk);
    drive(v.rd, v.wr, v.f3, v.addr, v.wd);
    #1;
    check({v.name, ".rd"},  bus.Read_data, v.exp_rd);
    check({v.name, ".mis"}, {31'h0, bus.misaligned}, {31'h0, v.exp_mis});
    check({v.name, ".err"}, {31'h0, bus.err_sticky}, {31'h0, v.exp_err});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

    // Store presented while in reset must be dropped.
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b010, 32'h20, 32'hAAAA5555);
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    #1;
    check("reset.rd",  bus.Read_data, 32'h0);
    check("reset.err", {31'h0, bus.err_sticky}, 32'h0);
    rst_n = 1'b1;

    //            name         rd    wr    f3      addr    wdata         exp_rd        mis   err
    vecs.push_back(mk("lw0",    1'b1, 1'b0, 3'b010, 32'h00, 32'h0,        32'h00000000, 1'b0, 1'b0));
    vecs.push_back(mk("drop",   1'b1, 1'b0, 3'b010, 32'h20, 32'h0,        32'h00000000, 1'b0, 1'b0));
    vecs.push_back(mk("sw10",   1'b0, 1'b1, 3'b010, 32'h10, 32'h876543A1, 32'h00000000, 1'b0, 1'b0));
    vecs.push_back(mk("lw10",   1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'h876543A1, 1'b0, 1'b0));
    vecs.push_back(mk("lb10",   1'b1, 1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFA1, 1'b0, 1'b0));
    vecs.push_back(mk("lbu10",  1'b1, 1'b0, 3'b100, 32'h10, 32'h0,        32'h000000A1, 1'b0, 1'b0));
    vecs.push_back(mk("lh12",   1'b1, 1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8765, 1'b0, 1'b0));
    vecs.push_back(mk("lhu12",  1'b1, 1'b0, 3'b101, 32'h12, 32'h0,        32'h00008765, 1'b0, 1'b0));
    vecs.push_back(mk("sb11",   1'b0, 1'b1, 3'b000, 32'h11, 32'hFFFFFF5C, 32'h00000000, 1'b0, 1'b0));
    vecs.push_back(mk("lw10b",  1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'h87655CA1, 1'b0, 1'b0));
    vecs.push_back(mk("lb11",   1'b1, 1'b0, 3'b000, 32'h11, 32'h0,        32'h0000005C, 1'b0, 1'b0));
    vecs.push_back(mk("lb13",   1'b1, 1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF87, 1'b0, 1'b0));
    vecs.push_back(mk("sh16",   1'b0, 1'b1, 3'b001, 32'h16, 32'h0000BEEF, 32'h00000000, 1'b0, 1'b0));
    vecs.push_back(mk("lw14",   1'b1, 1'b0, 3'b010, 32'h14, 32'h0,        32'hBEEF0000, 1'b0, 1'b0));
    vecs.push_back(mk("lh16",   1'b1, 1'b0, 3'b001, 32'h16, 32'h0,        32'hFFFFBEEF, 1'b0, 1'b0));
    vecs.push_back(mk("rdwr",   1'b1, 1'b1, 3'b010, 32'h10, 32'h11111111, 32'h87655CA1, 1'b0, 1'b0));
    vecs.push_back(mk("lw10c",  1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'h11111111, 1'b0, 1'b0));
    vecs.push_back(mk("idle",   1'b0, 1'b0, 3'b011, 32'h13, 32'h0,        32'h00000000, 1'b0, 1'b0));
    vecs.push_back(mk("sw16",   1'b0, 1'b1, 3'b010, 32'h16, 32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0));
    vecs.push_back(mk("lw14b",  1'b1, 1'b0, 3'b010, 32'h14, 32'h0,        32'hBEEF0000, 1'b0, 1'b1));
    vecs.push_back(mk("f3_011", 1'b1, 1'b0, 3'b011, 32'h14, 32'h0,        32'h00000000, 1'b1, 1'b1));
    vecs.push_back(mk("sbu",    1'b0, 1'b1, 3'b100, 32'h14, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1));
    vecs.push_back(mk("lh13",   1'b1, 1'b0, 3'b001, 32'h13, 32'h0,        32'h00000000, 1'b1, 1'b1));
    vecs.push_back(mk("lw14c",  1'b1, 1'b0, 3'b010, 32'h14, 32'h0,        32'hBEEF0000, 1'b0, 1'b1));

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
    end

    // Asynchronous reset clears the sticky flag and memory without a clock edge.
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.err", {31'h0, bus.err_sticky}, 32'h0);
    check("async_rst.rd",  bus.Read_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word index wraps modulo DEPTH.
    run_vec(mk("sw400", 1'b0, 1'b1, 3'b010, 32'h400, 32'h12345678, 32'h0,        1'b0, 1'b0));
    run_vec(mk("lw000", 1'b1, 1'b0, 3'b010, 32'h000, 32'h0,        32'h12345678, 1'b0, 1'b0));
    run_vec(mk("lw14r", 1'b1, 1'b0, 3'b010, 32'h014, 32'h0,        32'h00000000, 1'b0, 1'b0));

`ifdef DMEM_PERF_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    run_vec(mk("pc_l1", 1'b1, 1'b0, 3'b010, 32'h00, 32'h0, 32'h0, 1'b0, 1'b0));
    run_vec(mk("pc_s1", 1'b0, 1'b1, 3'b010, 32'h04, 32'h5, 32'h0, 1'b0, 1'b0));
    run_vec(mk("pc_l2", 1'b1, 1'b0, 3'b010, 32'h04, 32'h0, 32'h5, 1'b0, 1'b0));
    run_vec(mk("pc_bad",1'b0, 1'b1, 3'b010, 32'h06, 32'h7, 32'h0, 1'b1, 1'b0));
    run_vec(mk("pc_s2", 1'b0, 1'b1, 3'b000, 32'h08, 32'h9, 32'h0, 1'b0, 1'b1));
    run_vec(mk("pc_l3", 1'b1, 1'b0, 3'b100, 32'h08, 32'h0, 32'h9, 1'b0, 1'b1));
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    check("load_count",  load_count,  32'd3);
    check("store_count", store_count, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
